// File: rtl/cam_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_access_ctrl
// Description : Arbitrates lookup/insert/flush requests onto a 32x32 CAM,
//               qualifies hits against occupancy and allocates on insert miss.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_access_ctrl #(
   parameter int ENTRIES = 32,
   parameter int IDX_W   = 5,
   parameter int DATA_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lk_valid_i,
   output logic              lk_ready_o,
   input  logic [DATA_W-1:0] lk_key_i,
   output logic              lk_rsp_valid_o,
   output logic              lk_rsp_hit_o,
   output logic [IDX_W-1:0]  lk_rsp_index_o,
   input  logic              ins_valid_i,
   output logic              ins_ready_o,
   input  logic [DATA_W-1:0] ins_key_i,
   output logic              ins_rsp_valid_o,
   output logic [IDX_W-1:0]  ins_rsp_index_o,
   output logic              ins_rsp_new_o,
   output logic              ins_rsp_full_o,
   input  logic              flush_i,
   output logic              flush_ready_o,
   output logic              cam_search_enable_o,
   output logic [DATA_W-1:0] cam_search_data_o,
   input  logic              cam_search_valid_i,
   input  logic [IDX_W-1:0]  cam_search_index_i,
   output logic              cam_write_enable_o,
   output logic [IDX_W-1:0]  cam_write_index_o,
   output logic [DATA_W-1:0] cam_write_data_o,
   output logic [IDX_W:0]    occupancy_o,
   output logic              full_o
);

   localparam logic [IDX_W:0] c_entries = (IDX_W+1)'(ENTRIES);
   localparam logic [IDX_W:0] c_one     = (IDX_W+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SRCH  = 2'd1,
      ST_EVAL  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_key;
   logic              r_op_ins;
   logic              r_last_ins;
   logic [IDX_W:0]    r_occ;
   logic              r_lk_rsp_valid;
   logic              r_lk_rsp_hit;
   logic [IDX_W-1:0]  r_lk_rsp_index;
   logic              r_ins_rsp_valid;
   logic [IDX_W-1:0]  r_ins_rsp_index;
   logic              r_ins_rsp_new;
   logic              r_ins_rsp_full;

   logic w_idle;
   logic w_gnt_lk;
   logic w_gnt_ins;
   logic w_hit;
   logic w_full;

   // Everything combinational is held low while reset is asserted.
   assign w_idle    = rst_i && (r_state == ST_IDLE);
   assign w_gnt_lk  = w_idle && !flush_i && lk_valid_i  && (!ins_valid_i || r_last_ins);
   assign w_gnt_ins = w_idle && !flush_i && ins_valid_i && (!lk_valid_i  || !r_last_ins);
   // Lowest-match CAM plus contiguous allocation makes index<occupancy sufficient.
   assign w_hit     = cam_search_valid_i && ({1'b0, cam_search_index_i} < r_occ);
   assign w_full    = (r_occ == c_entries);

   assign lk_ready_o          = w_gnt_lk;
   assign ins_ready_o         = w_gnt_ins;
   assign flush_ready_o       = w_idle;
   assign cam_search_enable_o = rst_i && (r_state == ST_SRCH);
   assign cam_search_data_o   = r_key;
   assign cam_write_enable_o  = rst_i && (r_state == ST_WRITE);
   assign cam_write_index_o   = r_occ[IDX_W-1:0];
   assign cam_write_data_o    = r_key;
   assign occupancy_o         = r_occ;
   assign full_o              = w_full;

   assign lk_rsp_valid_o  = r_lk_rsp_valid;
   assign lk_rsp_hit_o    = r_lk_rsp_hit;
   assign lk_rsp_index_o  = r_lk_rsp_index;
   assign ins_rsp_valid_o = r_ins_rsp_valid;
   assign ins_rsp_index_o = r_ins_rsp_index;
   assign ins_rsp_new_o   = r_ins_rsp_new;
   assign ins_rsp_full_o  = r_ins_rsp_full;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state         <= ST_IDLE;
         r_key           <= '0;
         r_op_ins        <= 1'b0;
         r_last_ins      <= 1'b1;
         r_occ           <= '0;
         r_lk_rsp_valid  <= 1'b0;
         r_lk_rsp_hit    <= 1'b0;
         r_lk_rsp_index  <= '0;
         r_ins_rsp_valid <= 1'b0;
         r_ins_rsp_index <= '0;
         r_ins_rsp_new   <= 1'b0;
         r_ins_rsp_full  <= 1'b0;
      end else begin
         r_lk_rsp_valid  <= 1'b0;
         r_lk_rsp_hit    <= 1'b0;
         r_lk_rsp_index  <= '0;
         r_ins_rsp_valid <= 1'b0;
         r_ins_rsp_index <= '0;
         r_ins_rsp_new   <= 1'b0;
         r_ins_rsp_full  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (flush_i) begin
                  r_occ <= '0;
               end else if (w_gnt_lk || w_gnt_ins) begin
                  r_key      <= w_gnt_ins ? ins_key_i : lk_key_i;
                  r_op_ins   <= w_gnt_ins;
                  r_last_ins <= w_gnt_ins;
                  r_state    <= ST_SRCH;
               end
            end
            ST_SRCH: r_state <= ST_EVAL;
            ST_EVAL: begin
               r_state <= ST_IDLE;
               if (!r_op_ins) begin
                  r_lk_rsp_valid <= 1'b1;
                  r_lk_rsp_hit   <= w_hit;
                  r_lk_rsp_index <= w_hit ? cam_search_index_i : '0;
               end else if (w_hit) begin
                  r_ins_rsp_valid <= 1'b1;
                  r_ins_rsp_index <= cam_search_index_i;
               end else if (w_full) begin
                  r_ins_rsp_valid <= 1'b1;
                  r_ins_rsp_full  <= 1'b1;
               end else begin
                  r_state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (!w_full) begin
                  r_occ <= r_occ + c_one;
               end
               r_ins_rsp_valid <= 1'b1;
               r_ins_rsp_index <= r_occ[IDX_W-1:0];
               r_ins_rsp_new   <= 1'b1;
               r_state         <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cam_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_access_ctrl
// Description : Scoreboard bench for cam_access_ctrl with a behavioural CAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_access_ctrl;
   localparam int ENTRIES = 32;
   localparam int IDX_W   = 5;
   localparam int DATA_W  = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              lk_valid = 1'b0, lk_ready;
   logic [DATA_W-1:0] lk_key = '0;
   logic              lk_rsp_valid, lk_rsp_hit;
   logic [IDX_W-1:0]  lk_rsp_index;
   logic              ins_valid = 1'b0, ins_ready;
   logic [DATA_W-1:0] ins_key = '0;
   logic              ins_rsp_valid, ins_rsp_new, ins_rsp_full;
   logic [IDX_W-1:0]  ins_rsp_index;
   logic              flush = 1'b0, flush_ready;
   logic              cam_search_enable, cam_write_enable;
   logic [DATA_W-1:0] cam_search_data, cam_write_data;
   logic              cam_search_valid = 1'b0;
   logic [IDX_W-1:0]  cam_search_index = '0;
   logic [IDX_W-1:0]  cam_write_index;
   logic [IDX_W:0]    occupancy;
   logic              full;

   cam_access_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
      .clk_i(clk), .rst_i(rst),
      .lk_valid_i(lk_valid), .lk_ready_o(lk_ready), .lk_key_i(lk_key),
      .lk_rsp_valid_o(lk_rsp_valid), .lk_rsp_hit_o(lk_rsp_hit), .lk_rsp_index_o(lk_rsp_index),
      .ins_valid_i(ins_valid), .ins_ready_o(ins_ready), .ins_key_i(ins_key),
      .ins_rsp_valid_o(ins_rsp_valid), .ins_rsp_index_o(ins_rsp_index),
      .ins_rsp_new_o(ins_rsp_new), .ins_rsp_full_o(ins_rsp_full),
      .flush_i(flush), .flush_ready_o(flush_ready),
      .cam_search_enable_o(cam_search_enable), .cam_search_data_o(cam_search_data),
      .cam_search_valid_i(cam_search_valid), .cam_search_index_i(cam_search_index),
      .cam_write_enable_o(cam_write_enable), .cam_write_index_o(cam_write_index),
      .cam_write_data_o(cam_write_data),
      .occupancy_o(occupancy), .full_o(full)
   );

   always #5 clk = ~clk;

   // Behavioural CAM: lowest matching row, result one cycle after the strobe.
   logic [DATA_W-1:0] cam_mem [ENTRIES] = '{default: '0};
   always @(posedge clk) begin
      if (cam_write_enable) cam_mem[cam_write_index] <= cam_write_data;
      cam_search_valid <= 1'b0;
      cam_search_index <= '0;
      if (cam_search_enable) begin
         for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (cam_mem[i] == cam_search_data) begin
               cam_search_valid <= 1'b1;
               cam_search_index <= i[IDX_W-1:0];
            end
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic             hit;
      logic [IDX_W-1:0] idx;
      logic             nw;
      logic             full;
      int               cyc;
   } rsp_t;
   typedef struct {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      int                cyc;
   } wr_t;

   rsp_t lk_q[$];
   rsp_t ins_q[$];
   wr_t  wr_q[$];
   int   grant_log[$];

   logic [DATA_W-1:0] m_keys [ENTRIES];
   int   m_occ = 0;
   int   cyc = 0;
   int   wr_cnt = 0;
   int   ins_rsp_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int find_key(input logic [DATA_W-1:0] k);
      for (int i = 0; i < m_occ; i++) if (m_keys[i] == k) return i;
      return -1;
   endfunction

   rsp_t m_e;
   wr_t  m_w;
   int   m_f;

   // Monitor: compare outputs first, then record requests handshaking this cycle.
   always @(negedge clk) begin
      if (cam_write_enable) wr_cnt++;
      if (ins_rsp_valid) ins_rsp_cnt++;
      if (!rst) begin
         lk_q.delete(); ins_q.delete(); wr_q.delete();
         m_occ = 0;
      end else begin
         if (lk_rsp_valid) begin
            if (lk_q.size() == 0) check_val("lk_unexpected", 1, 0);
            else begin
               m_e = lk_q.pop_front();
               check_val("lk_hit", lk_rsp_hit, m_e.hit);
               check_val("lk_idx", lk_rsp_index, m_e.idx);
               check_val("lk_cycle", cyc, m_e.cyc);
            end
         end else check_val("lk_idle_zero", {lk_rsp_hit, lk_rsp_index}, 0);
         if (ins_rsp_valid) begin
            if (ins_q.size() == 0) check_val("ins_unexpected", 1, 0);
            else begin
               m_e = ins_q.pop_front();
               check_val("ins_idx", ins_rsp_index, m_e.idx);
               check_val("ins_new", ins_rsp_new, m_e.nw);
               check_val("ins_full", ins_rsp_full, m_e.full);
               check_val("ins_cycle", cyc, m_e.cyc);
            end
         end else check_val("ins_idle_zero", {ins_rsp_new, ins_rsp_full, ins_rsp_index}, 0);
         if (cam_write_enable) begin
            if (wr_q.size() == 0) check_val("wr_unexpected", 1, 0);
            else begin
               m_w = wr_q.pop_front();
               check_val("wr_idx", cam_write_index, m_w.idx);
               check_val("wr_data", cam_write_data, m_w.data);
               check_val("wr_cycle", cyc, m_w.cyc);
            end
         end
         if (lk_valid && lk_ready) begin
            grant_log.push_back(0);
            m_f = find_key(lk_key);
            m_e.hit = (m_f >= 0);
            m_e.idx = (m_f >= 0) ? IDX_W'(m_f) : '0;
            m_e.nw = 1'b0; m_e.full = 1'b0; m_e.cyc = cyc + 3;
            lk_q.push_back(m_e);
         end
         if (ins_valid && ins_ready) begin
            grant_log.push_back(1);
            m_f = find_key(ins_key);
            m_e.hit = 1'b0; m_e.nw = 1'b0; m_e.full = 1'b0; m_e.idx = '0; m_e.cyc = cyc + 3;
            if (m_f >= 0) m_e.idx = IDX_W'(m_f);
            else if (m_occ == ENTRIES) m_e.full = 1'b1;
            else begin
               m_e.idx = IDX_W'(m_occ); m_e.nw = 1'b1; m_e.cyc = cyc + 4;
               m_w.idx = IDX_W'(m_occ); m_w.data = ins_key; m_w.cyc = cyc + 3;
               wr_q.push_back(m_w);
               m_keys[m_occ] = ins_key;
               m_occ++;
            end
            ins_q.push_back(m_e);
         end
         if (flush && flush_ready) m_occ = 0;
      end
   end

   task automatic do_lookup(input logic [DATA_W-1:0] k);
      lk_key = k; lk_valid = 1'b1;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         if (lk_ready) break;
         if (n == 40) check_val("lk_ready_timeout", 0, 1);
      end
      @(posedge clk); #1 lk_valid = 1'b0;
   endtask

   task automatic do_insert(input logic [DATA_W-1:0] k);
      ins_key = k; ins_valid = 1'b1;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         if (ins_ready) break;
         if (n == 40) check_val("ins_ready_timeout", 0, 1);
      end
      @(posedge clk); #1 ins_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         if (flush_ready) break;
         if (n == 40) check_val("flush_ready_timeout", 0, 1);
      end
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check_val("flush_occ", occupancy, 0);
      check_val("flush_full", full, 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      for (int n = 0; n <= 60; n++) begin
         if (lk_q.size() == 0 && ins_q.size() == 0 && wr_q.size() == 0) break;
         if (n == 60) check_val("idle_timeout", 0, 1);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int c_wr, c_rsp;
   int arb_exp [4] = '{0, 1, 0, 1};

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_flush_rdy_low", flush_ready, 0);
      check_val("rst_wr_en_low", cam_write_enable, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check_val("rst_flush_rdy", flush_ready, 1);
      check_val("rst_readies", {lk_ready, ins_ready}, 0);
      check_val("rst_occ", occupancy, 0);
      check_val("rst_full", full, 0);
      check_val("rst_strobes", {cam_search_enable, cam_write_enable}, 0);
      check_val("rst_rsp", {lk_rsp_valid, ins_rsp_valid}, 0);
      @(posedge clk); #1;

      // Reset-content CAM row 0 matches key 0 but must not hit.
      do_lookup(32'h0000_0000);
      wait_idle();
      check_val("lk0_occ", occupancy, 0);

      do_insert(32'hA5A5_0001);
      wait_idle();
      check_val("ins1_occ", occupancy, 1);
      c_wr = wr_cnt;
      do_insert(32'hA5A5_0001);
      wait_idle();
      check_val("reins_no_write", wr_cnt, c_wr);

      for (int i = 1; i < ENTRIES; i++) do_insert(32'h1000_0000 + i);
      wait_idle();
      check_val("fill_full", full, 1);
      check_val("fill_occ", occupancy, 32);
      c_wr = wr_cnt;
      do_insert(32'hFFFF_0001);
      wait_idle();
      check_val("overflow_no_write", wr_cnt, c_wr);
      check_val("overflow_occ", occupancy, 32);
      do_lookup(32'h1000_0010);
      wait_idle();

      do_flush();
      for (int i = 0; i < 3; i++) do_insert(32'hC0DE_0000 + i);
      wait_idle();
      check_val("flush_pre_occ", occupancy, 3);
      do_flush();
      do_lookup(32'hC0DE_0001);
      do_insert(32'hC0DE_0009);
      wait_idle();
      check_val("k9_occ", occupancy, 1);

      // Both requesters held from reset: grants must alternate starting with lookup.
      rst = 1'b0;
      lk_key = 32'h5555_0000; lk_valid = 1'b1;
      ins_key = 32'h6666_0000; ins_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      grant_log.delete();
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (grant_log.size() >= 4) break;
      end
      lk_valid = 1'b0; ins_valid = 1'b0;
      wait_idle();
      for (int i = 0; i < 4; i++)
         check_val("arb_grant", (i < grant_log.size()) ? grant_log[i] : 99, arb_exp[i]);

      // Abort an allocating insert with reset during EVAL.
      c_wr = wr_cnt; c_rsp = ins_rsp_cnt;
      do_insert(32'h7777_0000);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_val("abort_eval_wr", wr_cnt, c_wr);
      check_val("abort_eval_rsp", ins_rsp_cnt, c_rsp);
      check_val("abort_eval_occ", occupancy, 0);
      @(posedge clk); #1;

      // Abort during WRITE: strobe must stay low while reset is asserted.
      c_wr = wr_cnt; c_rsp = ins_rsp_cnt;
      do_insert(32'h8888_0000);
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_val("abort_write_en", cam_write_enable, 0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("abort_write_cnt", wr_cnt, c_wr);
      check_val("abort_write_rsp", ins_rsp_cnt, c_rsp);
      check_val("abort_write_occ", occupancy, 0);
      @(posedge clk); #1;

      do_insert(32'h9999_0000);
      do_lookup(32'h9999_0000);
      do_lookup(32'h8888_0000);
      wait_idle();
      check_val("post_abort_occ", occupancy, 1);

      check_val("queues_drained", lk_q.size() + ins_q.size() + wr_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cam_access_ctrl.md
# cam_access_ctrl

Sequencer and arbiter in front of the 32x32 CAM. Two requesters share the CAM's search/write ports: a lookup client and an insert client. The block turns each request into a CAM search, qualifies the hit against its own occupancy count, allocates the next entry on an insert miss, and returns a one-cycle response pulse. It also provides a flush that logically empties the table without rewriting CAM contents.

## Interface
Parameters:
- ENTRIES, 32, number of CAM rows
- IDX_W, 5, index width
- DATA_W, 32, key width

Ports:
- clk_i  in  1  clock; all logic on posedge
- rst_i  in  1  synchronous, active-low reset
- lk_valid_i / lk_ready_o  in/out  1  lookup request handshake
- lk_key_i  in  DATA_W  lookup key
- lk_rsp_valid_o  out  1  lookup response pulse
- lk_rsp_hit_o  out  1  key present
- lk_rsp_index_o  out  IDX_W  matching index; 0 on miss
- ins_valid_i / ins_ready_o  in/out  1  insert request handshake
- ins_key_i  in  DATA_W  key to insert
- ins_rsp_valid_o  out  1  insert response pulse
- ins_rsp_index_o  out  IDX_W  existing or newly allocated index; 0 when full
- ins_rsp_new_o  out  1  entry was allocated and written
- ins_rsp_full_o  out  1  miss with table full; nothing written
- flush_i / flush_ready_o  in/out  1  flush handshake
- cam_search_enable_o  out  1  CAM search strobe
- cam_search_data_o  out  DATA_W  CAM search key
- cam_search_valid_i  in  1  CAM match found
- cam_search_index_i  in  IDX_W  CAM lowest matching index
- cam_write_enable_o  out  1  CAM write strobe
- cam_write_index_o  out  IDX_W  CAM write row
- cam_write_data_o  out  DATA_W  CAM write data
- occupancy_o  out  IDX_W+1  allocated entries, 0..ENTRIES
- full_o  out  1  occupancy_o == ENTRIES

## Operation
- CAM contract:
  - search_valid/index are valid the cycle after search_enable.
  - A write at edge N is visible to a search issued after edge N.
- Allocation is always at index = occupancy. There is no delete, so allocated rows are always the contiguous range 0..occupancy-1.
- Hit qualification: hit = cam_search_valid_i && (cam_search_index_i < occupancy).
  - Unallocated rows, including reset-content rows and stale rows left after a flush, never produce a hit.
  - This is correct because the CAM returns the lowest matching index.
- FSM states: IDLE, SRCH, EVAL, WRITE.
- IDLE behaviour:
  - flush_ready_o=1 in IDLE only.
  - flush_i wins over both requesters. A flush handshake sets occupancy to 0 at the next edge; state stays IDLE.
  - Otherwise, grant one valid requester and assert only its ready. The granted key and op are captured at the edge; go to SRCH.
  - Round-robin: if both are valid, grant the one not granted last. The pointer resets to favour lookup.
- SRCH: cam_search_enable_o=1, cam_search_data_o=key_q. Go to EVAL.
- EVAL, lookup: register the response (hit, index) and go to IDLE.
- EVAL, insert hit: register response index=match, new=0, full=0; go to IDLE.
- EVAL, insert miss and full: register response index=0, new=0, full=1; go to IDLE. No write.
- EVAL, insert miss and not full: go to WRITE.
- WRITE:
  - cam_write_enable_o=1, index=occupancy, data=key_q.
  - occupancy increments at the edge.
  - Register response index=old occupancy, new=1; go to IDLE.
- Responses are single-cycle pulses with no backpressure. Index/flag outputs are 0 when the corresponding valid is low.
- cam_write_data_o and cam_search_data_o drive key_q continuously. They are qualified only by the strobes.

## Timing
- Request accepted at cycle T, i.e. valid && ready in IDLE.
- SRCH is at T+1 and EVAL at T+2.
- Lookup response, insert hit response and insert full response are all at T+3.
- Insert-miss path:
  - WRITE is at T+3.
  - Response is at T+4; occupancy_o and full_o update at T+4.
- The FSM is back in IDLE in the response cycle and can accept a new request there. Throughput is one op per 3 cycles, or 4 for an allocating insert.
- Ready is combinational from state and valids. Ready is never high outside IDLE.
- Reset (rst_i=0 at an edge):
  - state IDLE, occupancy 0, RR pointer on lookup.
  - All outputs 0, except flush_ready_o=1 after reset releases.
- Reset in SRCH, EVAL or WRITE aborts the op: no response, no write. cam_write_enable_o is forced to 0 in any cycle where rst_i=0.
- occupancy saturates at ENTRIES and never wraps.

## Test plan
- Lookup after reset:
  - Stimulus: reset, then lookup key 0x00000000; CAM rows hold 0, so search_valid=1, index 0.
  - Required: lk_rsp_valid at T+3, hit=0, index=0; occupancy_o=0.
- Insert then re-insert:
  - Stimulus: insert 0xA5A50001 at T.
  - Required: write at T+3 (index 0, data 0xA5A50001); ins_rsp new=1, index=0 at T+4; occupancy_o=1.
  - Stimulus: insert the same key again.
  - Required: hit, new=0, index=0 at T+3; no write strobe.
- Fill to capacity:
  - Stimulus: insert 32 distinct keys, then insert a 33rd distinct key, then look up the 17th key.
  - Required: the 32 inserts get indices 0..31; full_o=1 and occupancy_o=32 afterwards.
  - Required: the 33rd insert returns full=1, index=0, no write.
  - Required: the lookup returns hit=1, index=16.
- Arbitration: lk_valid and ins_valid held high continuously from reset -> grants alternate lookup, insert, lookup, insert; the first grant is lookup.
- Flush:
  - Stimulus: 3 inserts (keys K0..K2), then flush_i in IDLE.
  - Required: occupancy_o=0 the next cycle.
  - Stimulus: lookup K1.
  - Required: miss (CAM reports index 1, disqualified).
  - Stimulus: insert new key K9.
  - Required: index 0, new=1.
- Reset mid-op:
  - Stimulus: rst_i=0 during the EVAL cycle of an insert miss.
  - Required: no cam_write_enable_o, no ins_rsp_valid_o, occupancy_o=0; the next request is accepted normally.
